// File: rtl/dcm_pkg.sv
// Shared constants, FSM encoding and period-decode helpers for the dcm monitor.
package dcm_pkg;

  localparam int unsigned MODE_W           = 3;
  localparam int unsigned NUM_MODES        = 8;
  localparam int unsigned CNT_W            = 8;
  localparam int unsigned LOCK_W           = 4;
  // 100 MHz system clock cycles in one half period of the 10 Hz reference.
  localparam int unsigned HALF_PERIOD_10HZ = 5_000_000;

  typedef enum logic [0:0] {
    WAIT_EDGE = 1'b0,
    MEASURE   = 1'b1
  } state_t;

  // True for 1,2,4,...,128; zero and every non-power-of-two are rejected.
  function automatic logic is_pow2(input logic [CNT_W-1:0] c);
    return (c != '0) && ((c & (c - 1'b1)) == '0);
  endfunction

  // Index of the highest set bit; only meaningful when is_pow2(c).
  function automatic logic [MODE_W-1:0] log2_mode(input logic [CNT_W-1:0] c);
    logic [MODE_W-1:0] m;
    m = '0;
    for (int i = 0; i < int'(CNT_W); i++) begin
      if (c[i]) m = MODE_W'(i);
    end
    return m;
  endfunction

endpackage

// File: rtl/dcm_freq_monitor_if.sv
// Clock observation inputs and measurement results between dcm and its monitor.
interface dcm_freq_monitor_if;
  import dcm_pkg::*;

  logic              clk_1;
  logic              clk_2;
  logic [MODE_W-1:0] prog_ref;
  logic [MODE_W-1:0] prog_det;
  logic              det_valid;
  logic              locked;
  logic              mismatch;
  logic              bad_period;
  logic              timeout;

  modport master (
    output clk_1, clk_2, prog_ref,
    input  prog_det, det_valid, locked, mismatch, bad_period, timeout
  );

  modport slave (
    input  clk_1, clk_2, prog_ref,
    output prog_det, det_valid, locked, mismatch, bad_period, timeout
  );
endinterface

// File: rtl/dcm_freq_monitor_sync_edge.sv
// Multi-stage synchronizer for an asynchronous level plus a registered rising-edge pulse.
module sync_edge #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise
);

  logic [STAGES-1:0] sync;
  logic              prev;

  // Shift the raw level through the sync chain and flag 0->1 transitions.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync <= '0;
      prev <= 1'b0;
      rise <= 1'b0;
    end else begin
      sync <= {sync[STAGES-2:0], din};
      prev <= sync[STAGES-1];
      rise <= sync[STAGES-1] & ~prev;
    end
  end

endmodule

// File: rtl/dcm_freq_monitor.sv
// Measures clk_2 periods in clk_1 edges, decodes the dcm mode and checks it against prog_ref.
module dcm_freq_monitor
  import dcm_pkg::*;
#(
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned LOCK_COUNT    = 2,
  parameter int unsigned TIMEOUT_TICKS = 255
) (
  input logic               clk,
  input logic               rst,
  dcm_freq_monitor_if.slave bus
);

  logic              e1;
  logic              e2;

  state_t            state;
  state_t            state_n;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_n;
  logic [CNT_W-1:0]  closing;
  logic [MODE_W-1:0] prog_det;
  logic [MODE_W-1:0] prog_det_n;
  logic              det_valid;
  logic              det_valid_n;
  logic [LOCK_W-1:0] lock_run;
  logic [LOCK_W-1:0] lock_run_n;
  logic              locked;
  logic              locked_n;
  logic              mismatch;
  logic              mismatch_n;
  logic              bad_period;
  logic              bad_period_n;
  logic              timeout;
  logic              timeout_n;

  sync_edge #(.STAGES(SYNC_STAGES)) u_sync_1 (
    .clk  (clk),
    .rst  (rst),
    .din  (bus.clk_1),
    .rise (e1)
  );

  sync_edge #(.STAGES(SYNC_STAGES)) u_sync_2 (
    .clk  (clk),
    .rst  (rst),
    .din  (bus.clk_2),
    .rise (e2)
  );

  // Period count as it would stand after this cycle's clk_1 edge (saturating).
  assign closing = e1 ? ((cnt == '1) ? cnt : cnt + 1'b1) : cnt;

  // State and result registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= WAIT_EDGE;
      cnt        <= '0;
      prog_det   <= '0;
      det_valid  <= 1'b0;
      lock_run   <= '0;
      locked     <= 1'b0;
      mismatch   <= 1'b0;
      bad_period <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      prog_det   <= prog_det_n;
      det_valid  <= det_valid_n;
      lock_run   <= lock_run_n;
      locked     <= locked_n;
      mismatch   <= mismatch_n;
      bad_period <= bad_period_n;
      timeout    <= timeout_n;
    end
  end

  // Next state: first clk_2 edge arms measuring, a stalled clk_2 drops back to waiting.
  always_comb begin
    state_n = state;
    case (state)
      WAIT_EDGE: if (e2) state_n = MEASURE;
      MEASURE:   if (!e2 && e1 && closing == CNT_W'(TIMEOUT_TICKS)) state_n = WAIT_EDGE;
      default:   state_n = WAIT_EDGE;
    endcase
  end

  // Counter, decode, lock tracking and status flags.
  always_comb begin
    cnt_n        = cnt;
    prog_det_n   = prog_det;
    det_valid_n  = 1'b0;
    lock_run_n   = lock_run;
    locked_n     = locked;
    bad_period_n = bad_period;
    timeout_n    = timeout;
    mismatch_n   = locked && (prog_det != bus.prog_ref);

    if (e2) timeout_n = 1'b0;

    case (state)
      WAIT_EDGE: cnt_n = '0;
      MEASURE: begin
        if (e2) begin
          cnt_n = '0;
          if (is_pow2(closing)) begin
            prog_det_n   = log2_mode(closing);
            det_valid_n  = 1'b1;
            bad_period_n = 1'b0;
            if (prog_det_n == prog_det) begin
              lock_run_n = (lock_run >= LOCK_W'(LOCK_COUNT)) ? LOCK_W'(LOCK_COUNT)
                                                             : lock_run + 1'b1;
            end else begin
              lock_run_n = LOCK_W'(1);
            end
            locked_n = (lock_run_n == LOCK_W'(LOCK_COUNT));
          end else begin
            bad_period_n = 1'b1;
            lock_run_n   = '0;
            locked_n     = 1'b0;
          end
        end else if (e1) begin
          cnt_n = closing;
          if (closing == CNT_W'(TIMEOUT_TICKS)) begin
            cnt_n      = '0;
            timeout_n  = 1'b1;
            lock_run_n = '0;
            locked_n   = 1'b0;
          end
        end
      end
      default: cnt_n = '0;
    endcase
  end

  assign bus.prog_det   = prog_det;
  assign bus.det_valid  = det_valid;
  assign bus.locked     = locked;
  assign bus.mismatch   = mismatch;
  assign bus.bad_period = bad_period;
  assign bus.timeout    = timeout;

endmodule

// File: doc/dcm_freq_monitor.md
Name: dcm_freq_monitor

Overview:
- Receiving end of the dcm clock outputs: observes clk_1 (10 Hz reference) and clk_2 (programmable slow clock).
- Measures each clk_2 period in whole clk_1 periods and decodes the active mode (0..7, clk_2 = 10 Hz / 2^mode).
- Compares the decoded mode against the dcm's reported prog_out, flagging mismatch, bad period and stopped clock.
- Sits beside dcm in the top level; all logic runs on the 100 MHz clk. clk_1 and clk_2 are sampled as data, never used as clocks.

Parameters:
- SYNC_STAGES, 2, flip-flop depth of each input synchronizer (minimum 2).
- LOCK_COUNT, 2, consecutive identical valid measurements required to assert locked (1..15).
- TIMEOUT_TICKS, 255, clk_1 rising edges without a clk_2 rising edge before timeout asserts (must exceed 128).

Ports:
- clk, input, 1, 100 MHz system clock.
- rst, input, 1, synchronous, active-low reset.
- clk_1, input, 1, fast reference clock from dcm (treated as async data).
- clk_2, input, 1, slow programmable clock from dcm (treated as async data).
- prog_ref, input, 3, mode the dcm reports (its prog_out).
- prog_det, output, 3, last decoded mode.
- det_valid, output, 1, one-cycle pulse when a measurement completes and is a valid power of two.
- locked, output, 1, LOCK_COUNT consecutive equal valid measurements seen.
- mismatch, output, 1, locked and prog_det != prog_ref.
- bad_period, output, 1, sticky; last completed measurement was not a power of two in 1..128.
- timeout, output, 1, clk_2 stalled for TIMEOUT_TICKS clk_1 edges.

Behaviour:
- Reset: applied when rst == 0 on a clk edge. All outputs, counters and synchronizers go to 0; FSM enters WAIT_EDGE.
- Input conditioning:
  - clk_1 and clk_2 each pass through a SYNC_STAGES synchronizer.
  - Rising edge = synchronized value is 1 and the previous sample was 0.
  - e1 and e2 are single-cycle pulses.
- Period counter: 8-bit count of e1 pulses, saturating at 255.
- Coincidence rule: if e1 and e2 fire in the same cycle, that e1 counts toward the period being closed. The new period starts at 0.
- WAIT_EDGE:
  - Counter held at 0 and ignores e1.
  - On the first e2, go to MEASURE.
  - The first partial period is always discarded.
- MEASURE:
  - Each e1 increments the counter.
  - On e2, evaluate the closing count C (including any coincident e1):
    - C in {1,2,4,...,128}: prog_det <= log2(C), det_valid pulses next cycle, bad_period clears.
    - Otherwise: bad_period <= 1, lock_run <= 0, locked <= 0, prog_det unchanged, no det_valid.
  - The counter restarts and the FSM stays in MEASURE.
- Lock tracking, on each valid measurement:
  - If the new prog_det equals the previous valid one, increment lock_run (saturating at LOCK_COUNT); otherwise set lock_run to 1.
  - locked = (lock_run == LOCK_COUNT).
  - A decoded mode change clears locked the same cycle the new value is registered.
- Latency: e2 is detected SYNC_STAGES+1 clk cycles after the clk_2 rising edge. prog_det, det_valid and locked update 1 cycle after e2.
- Timeout:
  - In MEASURE, when the counter reaches TIMEOUT_TICKS without an e2: timeout <= 1, locked <= 0, lock_run <= 0, FSM to WAIT_EDGE.
  - timeout clears on the next e2.
- mismatch: registered as locked && (prog_det != prog_ref), evaluated every cycle. A prog_ref change takes effect in 1 cycle.
- Reset mid-measurement: the partial count is discarded and the FSM restarts in WAIT_EDGE.

Decomposition:
- Shared package dcm_pkg:
  - MODE_W = 3 and NUM_MODES = 8.
  - Constant 100 MHz → 10 Hz half-period count (5,000,000).
  - FSM state encoding (WAIT_EDGE, MEASURE).
- One natural sub-module, sync_edge: a parameterized SYNC_STAGES synchronizer plus rising-edge pulse. It is instantiated twice, once for clk_1 and once for clk_2.

Test Plan:
- Bench drives clk_1 and clk_2 as pulse trains on clk, not at real-time rates.
- Scenarios:
  - Mode 3: 8 clk_1 edges per clk_2 period, prog_ref = 3, 4 periods → prog_det = 3, det_valid pulses 3 times, locked = 1 after the 3rd clk_2 edge, mismatch = 0.
  - Locked at mode 3, prog_ref switched to 5 → mismatch = 1 one cycle later. Then drive 32-edge periods → locked drops at the first valid 32-count, relocks after 2, mismatch returns to 0.
  - Mode 0 with clk_1 and clk_2 edges coincident every period → C = 1, prog_det = 0, locked after 2 measurements.
  - Period of 6 clk_1 edges → bad_period = 1, locked = 0, prog_det retains its prior value. Next 4-edge period → bad_period = 0, prog_det = 2.
  - clk_2 held low for 255 clk_1 edges → timeout = 1, locked = 0. Resume mode 7 → timeout clears on the first edge, locked after 2 full 128-edge periods.
  - rst = 0 for 1 cycle mid-period at mode 4 → all outputs 0, and the first post-reset partial period produces no det_valid.
